// File: rtl/relu_sched_pkg.sv
// ---------------------------------------------------------------------------
// relu_sched_pkg
// Shared types and helpers for the ReLU layer scheduler.
//   sched_state_e : scheduler FSM state encoding
//   idx_width()   : bits needed to index n neurons (minimum 1)
// ---------------------------------------------------------------------------
package relu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    // ceil(log2(n)), never less than 1 so a 1-bit index is always legal
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/relu_sched_relu.sv
// ---------------------------------------------------------------------------
// relu_sched_relu
// Combinational ReLU from a signed 2*data_width accumulator to an unsigned
// data_width activation. Negative inputs give 0; positive inputs larger than
// the activation range saturate to all ones.
// Ports:
//   din  in  2*data_width  signed accumulator value
//   dout out data_width    activation
// ---------------------------------------------------------------------------
module relu_sched_relu #(
    parameter int data_width = 4
) (
    input  logic [2*data_width-1:0] din,
    output logic [data_width-1:0]   dout
);

    logic neg;
    logic ovf;

    assign neg = din[2*data_width-1];
    // any set bit between the sign and the activation field means the value
    // does not fit in data_width unsigned bits
    assign ovf = |din[2*data_width-2:data_width];

    always_comb begin
        dout = din[data_width-1:0];
        if (neg) begin
            dout = '0;
        end else if (ovf) begin
            dout = '1;
        end
    end

endmodule

// File: rtl/relu_layer_scheduler.sv
// ---------------------------------------------------------------------------
// relu_layer_scheduler
// Time-multiplexes one ReLU across all neuron accumulators of a layer.
// A full accumulator vector is captured on the input handshake, then one
// neuron per cycle is passed through the ReLU into an output register that
// drives an indexed valid/ready stream. Accepted activations are also
// collected into a packed vector.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for an accumulator vector (acc_ready=1)
// RUN   | feeding buffer[idx] through the ReLU into the output register
// DRAIN | last element loaded, waiting for it to be accepted
// DONE  | layer complete, layer_done pulses for this single cycle
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   flush       in   synchronous abort back to IDLE
//   acc_valid   in   accumulator vector valid
//   acc_ready   out  scheduler can accept a vector
//   acc_data    in   packed accumulators, neuron i at [i*2W +: 2W]
//   out_valid   out  activation valid
//   out_ready   in   downstream accepts activation
//   out_data    out  ReLU(acc[out_idx])
//   out_idx     out  neuron index of out_data
//   out_last    out  out_data is the final neuron
//   act_vec     out  packed accepted activations, neuron i at [i*W +: W]
//   layer_done  out  one-cycle pulse after the last element is accepted
// ---------------------------------------------------------------------------
module relu_layer_scheduler
    import relu_sched_pkg::*;
#(
    parameter int  DATA_WIDTH  = 4,
    parameter int  NUM_NEURONS = 4,
    localparam int IDX_W       = idx_width(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              acc_valid,
    output logic                              acc_ready,
    input  logic [NUM_NEURONS*2*DATA_WIDTH-1:0] acc_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [IDX_W-1:0]                  out_idx,
    output logic                              out_last,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] act_vec,
    output logic                              layer_done
);

    localparam int              ACC_W    = 2 * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    sched_state_e state_q;
    sched_state_e state_d;

    logic [NUM_NEURONS-1:0][ACC_W-1:0]      buf_q;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] act_q;
    logic [IDX_W-1:0]                       idx_q;
    logic [DATA_WIDTH-1:0]                  relu_out;

    logic acc_fire;
    logic out_fire;
    logic load_en;
    logic idx_at_last;

    assign acc_fire    = acc_valid && acc_ready;
    assign out_fire    = out_valid && out_ready;
    assign idx_at_last = (idx_q == LAST_IDX);
    // output register is free when empty or being drained this cycle
    assign load_en     = (state_q == RUN) && (!out_valid || out_ready);
    assign act_vec     = act_q;

    relu_sched_relu #(
        .data_width(DATA_WIDTH)
    ) u_relu (
        .din (buf_q[idx_q]),
        .dout(relu_out)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (acc_fire) state_d = RUN;
                RUN:     if (load_en && idx_at_last) state_d = DRAIN;
                DRAIN:   if (out_fire) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // state-decoded outputs
    always_comb begin
        acc_ready  = 1'b0;
        layer_done = 1'b0;
        case (state_q)
            IDLE:    acc_ready  = 1'b1;
            DONE:    layer_done = 1'b1;
            default: ;
        endcase
    end

    // datapath: input buffer, element index, output register, result vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            act_q     <= '0;
        end else if (flush) begin
            // act_q deliberately keeps the partially collected layer
            out_valid <= 1'b0;
            idx_q     <= '0;
        end else begin
            if (acc_fire) begin
                buf_q <= acc_data;
                idx_q <= '0;
            end
            if (out_fire) begin
                act_q[out_idx] <= out_data;
            end
            if (load_en) begin
                out_data  <= relu_out;
                out_idx   <= idx_q;
                out_last  <= idx_at_last;
                out_valid <= 1'b1;
                // index parks on the last neuron instead of wrapping
                if (!idx_at_last) begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relu_layer_scheduler.sv
module tb_relu_layer_scheduler;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int AW = 2 * W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             acc_valid;
    logic             acc_ready;
    logic [N*AW-1:0]  acc_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [IW-1:0]    out_idx;
    logic             out_last;
    logic [N*W-1:0]   act_vec;
    logic             layer_done;

    relu_layer_scheduler #(
        .DATA_WIDTH (W),
        .NUM_NEURONS(N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_data  (acc_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .act_vec   (act_vec),
        .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N*W-1:0] exp_act;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference ReLU: signed accumulator, clamp to [0, 2^W-1]
    function automatic logic [W-1:0] relu_ref(input logic [AW-1:0] a);
        int v;
        v = int'($signed(a));
        if (v < 0) return '0;
        if (v > (1 << W) - 1) return '1;
        return W'(v);
    endfunction

    task automatic start_layer(input logic [N*AW-1:0] v);
        acc_valid = 1'b1;
        acc_data  = v;
        check("acc_ready_idle", 64'(acc_ready), 64'(1));
        @(negedge clk);
        acc_valid = 1'b0;
    endtask

    // rmode: 0 ready high, 1 random ready, 2 three-cycle stall on idx 1
    // imode: 0 quiet input, 1 random ignored acc_valid, 2 hold nextv valid
    task automatic stream_layer(input logic [N*AW-1:0] v, input int rmode,
                                input int imode, input logic [N*AW-1:0] nextv);
        logic [W-1:0]  qd[$];
        int            qi[$];
        int            stalls = 0;
        int            stall_left = 0;
        bit            stalled_once = 0;
        bit            done = 0;
        bit            prev_stall = 0;
        int unsigned   base;
        logic [W-1:0]  pd;
        logic [IW-1:0] pi;
        logic          pl;
        base = cyc;
        for (int i = 0; i < N; i++) begin
            qd.push_back(relu_ref(v[i*AW +: AW]));
            qi.push_back(i);
        end
        for (int k = 0; k < 200 && !done; k++) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && out_idx == 2'd1 && !stalled_once) begin
                        stall_left   = 3;
                        stalled_once = 1;
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            case (imode)
                1: begin
                    acc_valid = 1'($urandom_range(0, 1));
                    acc_data  = $urandom;
                end
                2: begin
                    acc_valid = 1'b1;
                    acc_data  = nextv;
                end
                default: acc_valid = 1'b0;
            endcase
            check("acc_ready_busy", 64'(acc_ready), 64'(0));
            if (prev_stall) begin
                check("hold_data", 64'(out_data), 64'(pd));
                check("hold_idx",  64'(out_idx),  64'(pi));
                check("hold_last", 64'(out_last), 64'(pl));
            end
            if (layer_done) begin
                check("pending_elements", 64'(qd.size()), 64'(0));
                check("act_vec_done", 64'(act_vec), 64'(exp_act));
                check("done_latency", 64'(cyc - base), 64'(N + 1 + stalls));
                done = 1;
            end else if (out_valid && out_ready) begin
                if (qd.size() == 0) begin
                    check("extra_element", 64'(1), 64'(0));
                end else begin
                    check("out_idx",  64'(out_idx),  64'(qi[0]));
                    check("out_data", 64'(out_data), 64'(qd[0]));
                    check("out_last", 64'(out_last), 64'(qi[0] == N - 1));
                    exp_act[qi[0]*W +: W] = qd[0];
                    void'(qd.pop_front());
                    void'(qi.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready && !layer_done;
            pd = out_data;
            pi = out_idx;
            pl = out_last;
            if (prev_stall) stalls++;
            if (!done) @(negedge clk);
        end
        if (!done) check("layer_done_timeout", 64'(0), 64'(1));
        if (imode != 2) acc_valid = 1'b0;
        @(negedge clk);
        check("acc_ready_again",  64'(acc_ready),  64'(1));
        check("done_pulse_width", 64'(layer_done), 64'(0));
    endtask

    initial begin
        logic [N*AW-1:0] v1;
        logic [N*AW-1:0] v2;
        int accepts;
        bit seen;

        rst_n     = 1'b0;
        flush     = 1'b0;
        acc_valid = 1'b0;
        out_ready = 1'b0;
        acc_data  = '0;
        exp_act   = '0;

        // reset state
        @(negedge clk);
        check("rst_out_valid",  64'(out_valid),  64'(0));
        check("rst_out_data",   64'(out_data),   64'(0));
        check("rst_out_idx",    64'(out_idx),    64'(0));
        check("rst_out_last",   64'(out_last),   64'(0));
        check("rst_act_vec",    64'(act_vec),    64'(0));
        check("rst_layer_done", 64'(layer_done), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_acc_ready", 64'(acc_ready), 64'(1));

        // basic layer: neurons 3..0 = 80, 10, 02, F0
        v1 = {8'h80, 8'h10, 8'h02, 8'hF0};
        start_layer(v1);
        stream_layer(v1, 0, 0, '0);
        check("basic_act_vec", 64'(act_vec), 64'(16'h0F20));

        // backpressure on idx 1 for three cycles
        v1 = {8'h05, 8'h7F, 8'h09, 8'h03};
        start_layer(v1);
        stream_layer(v1, 2, 0, '0);

        // random layers, random backpressure, ignored acc_valid pulses
        for (int r = 0; r < 4; r++) begin
            v1 = $urandom;
            start_layer(v1);
            stream_layer(v1, 1, 1, '0);
        end

        // back-to-back layers with acc_valid held high
        v1 = {8'h01, 8'hFF, 8'h0C, 8'h06};
        v2 = {8'h0E, 8'h04, 8'hC0, 8'h0B};
        start_layer(v1);
        stream_layer(v1, 0, 2, v2);
        start_layer(v2);
        stream_layer(v2, 0, 0, '0);
        check("b2b_act_vec", 64'(act_vec), 64'(exp_act));

        // flush after two elements accepted
        v1 = {8'h07, 8'h06, 8'h05, 8'h04};
        start_layer(v1);
        out_ready = 1'b1;
        accepts = 0;
        for (int k = 0; k < 20 && accepts < 2; k++) begin
            if (out_valid && out_ready) begin
                check("flush_pre_idx",  64'(out_idx),  64'(accepts));
                check("flush_pre_data", 64'(out_data), 64'(relu_ref(v1[accepts*AW +: AW])));
                exp_act[accepts*W +: W] = relu_ref(v1[accepts*AW +: AW]);
                accepts++;
            end
            @(negedge clk);
        end
        check("flush_two_accepts", 64'(accepts), 64'(2));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_out_valid",  64'(out_valid),  64'(0));
        check("flush_acc_ready",  64'(acc_ready),  64'(1));
        check("flush_layer_done", 64'(layer_done), 64'(0));
        check("flush_act_vec",    64'(act_vec),    64'(exp_act));
        @(negedge clk);
        check("flush_no_done", 64'(layer_done), 64'(0));
        v1 = {8'h02, 8'h81, 8'h0F, 8'h30};
        start_layer(v1);
        stream_layer(v1, 1, 0, '0);

        // reset while an element is valid
        v1 = {8'h03, 8'h03, 8'h03, 8'h03};
        start_layer(v1);
        out_ready = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (out_valid) seen = 1;
            else @(negedge clk);
        end
        check("mid_run_valid", 64'(seen), 64'(1));
        rst_n = 1'b0;
        #1;
        exp_act = '0;
        check("mrst_out_valid",  64'(out_valid),  64'(0));
        check("mrst_out_data",   64'(out_data),   64'(0));
        check("mrst_out_idx",    64'(out_idx),    64'(0));
        check("mrst_out_last",   64'(out_last),   64'(0));
        check("mrst_act_vec",    64'(act_vec),    64'(0));
        check("mrst_layer_done", 64'(layer_done), 64'(0));
        @(negedge clk);
        check("mrst_no_done", 64'(layer_done), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_acc_ready", 64'(acc_ready), 64'(1));
        v1 = $urandom;
        start_layer(v1);
        stream_layer(v1, 1, 1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
